pipeline_mem_stage: RTL and testbench



---
 rtl/pipeline_mem_stage.sv | 206 ++++++++++++++++++++
 tb/tb_pipeline_mem_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem_stage.sv
// MIPS MEM stage: issues dcache requests, stalls upstream until dhit, registers MEM/WB fields, tracks halt.
// Optional LL/SC link tracking is built when PIPELINE_MEM_LLSC_EN is defined.
module pipeline_mem_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_porto,
    input  logic [DW-1:0] ex_portb,
    input  logic [DW-1:0] ex_imemaddr,
    input  logic [DW-1:0] ex_extimm,
    input  logic [RW-1:0] ex_wsel,
    input  logic          ex_dmemREN,
    input  logic          ex_dmemWEN,
    input  logic          ex_regwr,
    input  logic [1:0]    ex_regsrc,
    input  logic          ex_halt,
`ifdef PIPELINE_MEM_LLSC_EN
    input  logic          ex_ll,
    input  logic          ex_sc,
    input  logic          ccinv,
    input  logic [DW-1:0] ccsnoopaddr,
`endif
    input  logic          dhit,
    input  logic [DW-1:0] dmemload,
    output logic          dmemREN,
    output logic          dmemWEN,
    output logic [DW-1:0] dmemaddr,
    output logic [DW-1:0] dmemstore,
    output logic          mem_stall,
    output logic          wb_valid,
    output logic [DW-1:0] wb_wdat,
    output logic [RW-1:0] wb_wsel,
    output logic          wb_regwr,
    output logic          wb_halt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state_r;
    logic [RW-1:0] req_wsel_r;
    logic          req_regwr_r;
    logic [1:0]    req_regsrc_r;
    logic [DW-1:0] alu_wdat_s;
    logic          rd_req_s;
    logic          wr_req_s;
    logic          sc_fail_s;
`ifdef PIPELINE_MEM_LLSC_EN
    logic          req_ll_r;
    logic          req_sc_r;
    logic          link_valid_r;
    logic [DW-1:0] link_addr_r;
    logic          link_hit_s;
`endif

    // Writeback source mux for single-cycle (non-memory) ops; regsrc=1 without a load yields zero.
    always_comb begin
        alu_wdat_s = {DW{1'b0}};
        case (ex_regsrc)
            2'd0:    alu_wdat_s = ex_porto;
            2'd1:    alu_wdat_s = {DW{1'b0}};
            2'd2:    alu_wdat_s = ex_imemaddr;
            2'd3:    alu_wdat_s = ex_extimm;
            default: alu_wdat_s = {DW{1'b0}};
        endcase
    end

    // Request decode: a write beats a read; a failing SC never reaches the cache.
    always_comb begin
`ifdef PIPELINE_MEM_LLSC_EN
        link_hit_s = link_valid_r && (link_addr_r == ex_porto);
        sc_fail_s  = ex_sc && !link_hit_s;
        if (ex_sc) begin
            wr_req_s = link_hit_s;
        end else begin
            wr_req_s = ex_dmemWEN;
        end
        rd_req_s = (ex_dmemREN || ex_ll) && !wr_req_s && !sc_fail_s;
`else
        sc_fail_s = 1'b0;
        wr_req_s  = ex_dmemWEN;
        rd_req_s  = ex_dmemREN && !ex_dmemWEN;
`endif
    end

    // Upstream hold: released in the dhit cycle so the latch advances exactly once per op.
    always_comb begin
        mem_stall = ((state_r == WAIT) && !dhit) || (state_r == HALTED);
    end

    // Stage FSM with registered cache strobes and MEM/WB fields.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= IDLE;
            dmemREN      <= 1'b0;
            dmemWEN      <= 1'b0;
            dmemaddr     <= {DW{1'b0}};
            dmemstore    <= {DW{1'b0}};
            wb_valid     <= 1'b0;
            wb_wdat      <= {DW{1'b0}};
            wb_wsel      <= {RW{1'b0}};
            wb_regwr     <= 1'b0;
            wb_halt      <= 1'b0;
            req_wsel_r   <= {RW{1'b0}};
            req_regwr_r  <= 1'b0;
            req_regsrc_r <= 2'd0;
`ifdef PIPELINE_MEM_LLSC_EN
            req_ll_r     <= 1'b0;
            req_sc_r     <= 1'b0;
            link_valid_r <= 1'b0;
            link_addr_r  <= {DW{1'b0}};
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef PIPELINE_MEM_LLSC_EN
            // A snoop invalidate kills the link; an LL completing this cycle overrides below.
            if (ccinv && (ccsnoopaddr == link_addr_r)) begin
                link_valid_r <= 1'b0;
            end
`endif
            case (state_r)
                IDLE: begin
                    if (ex_valid) begin
                        if (ex_halt) begin
                            wb_halt  <= 1'b1;
                            wb_valid <= 1'b1;
                            wb_regwr <= 1'b0;
                            state_r  <= HALTED;
                        end else if (sc_fail_s) begin
                            wb_valid <= 1'b1;
                            wb_wdat  <= {DW{1'b0}};
                            wb_wsel  <= ex_wsel;
                            wb_regwr <= 1'b1;
`ifdef PIPELINE_MEM_LLSC_EN
                            link_valid_r <= 1'b0;
`endif
                        end else if (rd_req_s || wr_req_s) begin
                            dmemREN      <= rd_req_s;
                            dmemWEN      <= wr_req_s;
                            dmemaddr     <= ex_porto;
                            dmemstore    <= ex_portb;
                            req_wsel_r   <= ex_wsel;
                            req_regwr_r  <= ex_regwr;
                            req_regsrc_r <= ex_regsrc;
`ifdef PIPELINE_MEM_LLSC_EN
                            req_ll_r     <= ex_ll;
                            req_sc_r     <= ex_sc;
`endif
                            state_r      <= WAIT;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_wdat  <= alu_wdat_s;
                            wb_wsel  <= ex_wsel;
                            wb_regwr <= ex_regwr;
                        end
                    end
                end
                WAIT: begin
                    if (dhit) begin
                        dmemREN  <= 1'b0;
                        dmemWEN  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_wsel  <= req_wsel_r;
                        state_r  <= IDLE;
                        if (dmemREN) begin
                            wb_wdat  <= dmemload;
                            wb_regwr <= req_regwr_r;
`ifdef PIPELINE_MEM_LLSC_EN
                            if (req_ll_r) begin
                                link_valid_r <= 1'b1;
                                link_addr_r  <= dmemaddr;
                            end
`endif
                        end else begin
                            wb_wdat  <= (req_regsrc_r == 2'd0) ? dmemaddr : {DW{1'b0}};
                            wb_regwr <= 1'b0;
`ifdef PIPELINE_MEM_LLSC_EN
                            if (req_sc_r) begin
                                wb_wdat      <= {{(DW-1){1'b0}}, 1'b1};
                                wb_regwr     <= 1'b1;
                                link_valid_r <= 1'b0;
                            end
`endif
                        end
                    end
                end
                HALTED: begin
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed self-checking bench for pipeline_mem_stage; covers the LL/SC path when PIPELINE_MEM_LLSC_EN is defined.
module tb_pipeline_mem_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          ex_valid, ex_dmemREN, ex_dmemWEN, ex_regwr, ex_halt, dhit;
    logic [DW-1:0] ex_porto, ex_portb, ex_imemaddr, ex_extimm, dmemload;
    logic [RW-1:0] ex_wsel;
    logic [1:0]    ex_regsrc;
    logic          dmemREN, dmemWEN, mem_stall, wb_valid, wb_regwr, wb_halt;
    logic [DW-1:0] dmemaddr, dmemstore, wb_wdat;
    logic [RW-1:0] wb_wsel;
`ifdef PIPELINE_MEM_LLSC_EN
    logic          ex_ll, ex_sc, ccinv;
    logic [DW-1:0] ccsnoopaddr;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    pipeline_mem_stage #(.DW(DW), .RW(RW)) dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_porto(ex_porto), .ex_portb(ex_portb),
        .ex_imemaddr(ex_imemaddr), .ex_extimm(ex_extimm), .ex_wsel(ex_wsel),
        .ex_dmemREN(ex_dmemREN), .ex_dmemWEN(ex_dmemWEN), .ex_regwr(ex_regwr),
        .ex_regsrc(ex_regsrc), .ex_halt(ex_halt),
`ifdef PIPELINE_MEM_LLSC_EN
        .ex_ll(ex_ll), .ex_sc(ex_sc), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
`endif
        .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_wdat(wb_wdat), .wb_wsel(wb_wsel),
        .wb_regwr(wb_regwr), .wb_halt(wb_halt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_dmemREN = 1'b0; ex_dmemWEN = 1'b0; ex_regwr = 1'b0; ex_halt = 1'b0;
        ex_porto = 32'h0; ex_portb = 32'h0; ex_imemaddr = 32'h0; ex_extimm = 32'h0;
        ex_wsel = 5'd0; ex_regsrc = 2'd0; dhit = 1'b0; dmemload = 32'h0;
`ifdef PIPELINE_MEM_LLSC_EN
        ex_ll = 1'b0; ex_sc = 1'b0; ccinv = 1'b0; ccsnoopaddr = 32'h0;
`endif
    endtask

    task automatic test_reset();
        clear_ex();
        RST = 1'b1;
        tick();
        n_checks++;
        if ({dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wb_valid, wb_wdat, wb_wsel, wb_regwr, wb_halt} !== 107'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got REN=%b WEN=%b stall=%b wbv=%b wdat=%h halt=%b, expected all zero",
                     dmemREN, dmemWEN, mem_stall, wb_valid, wb_wdat, wb_halt);
        end
        RST = 1'b0;
    endtask

    task automatic test_alu();
        logic [DW-1:0] exp_w;
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; ex_regsrc = i[1:0]; ex_porto = 32'h0000_1234;
            ex_imemaddr = 32'h0040_0008; ex_extimm = 32'hABCD_0000;
            ex_wsel = 5'(5 + i); ex_regwr = 1'b1;
            case (i)
                0:       exp_w = 32'h0000_1234;
                1:       exp_w = 32'h0;
                2:       exp_w = 32'h0040_0008;
                default: exp_w = 32'hABCD_0000;
            endcase
            n_checks++;
            if (mem_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL alu_stall_pre[%0d]: got %b expected 0", i, mem_stall);
            end
            tick();
            ex_valid = 1'b0;
            n_checks++;
            if ({wb_valid, wb_wdat, wb_wsel, wb_regwr, mem_stall, dmemREN, dmemWEN} !== {1'b1, exp_w, 5'(5 + i), 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL alu_retire[%0d]: got v=%b wdat=%h wsel=%0d rw=%b stall=%b, expected v=1 wdat=%h wsel=%0d rw=1 stall=0",
                         i, wb_valid, wb_wdat, wb_wsel, wb_regwr, mem_stall, exp_w, 5 + i);
            end
        end
        tick();
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_pulse: wb_valid got %b expected 0", wb_valid);
        end
    endtask

    task automatic test_load();
        clear_ex();
        ex_valid = 1'b1; ex_dmemREN = 1'b1; ex_porto = 32'h0000_0100; ex_wsel = 5'd7;
        ex_regwr = 1'b1; ex_regsrc = 2'd1;
        tick();
        clear_ex();
        dmemload = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            dhit = (i == 3);
            #1;
            n_checks++;
            if ({dmemREN, dmemWEN, dmemaddr, mem_stall, wb_valid} !== {1'b1, 1'b0, 32'h0000_0100, (i < 3), 1'b0}) begin
                n_fail++;
                $display("FAIL load_wait[%0d]: got REN=%b WEN=%b addr=%h stall=%b wbv=%b, expected REN=1 WEN=0 addr=00000100 stall=%b wbv=0",
                         i, dmemREN, dmemWEN, dmemaddr, mem_stall, wb_valid, (i < 3));
            end
            tick();
        end
        dhit = 1'b0;
        n_checks++;
        if ({dmemREN, wb_valid, wb_wdat, wb_wsel, wb_regwr, mem_stall} !== {1'b0, 1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL load_retire: got REN=%b v=%b wdat=%h wsel=%0d rw=%b stall=%b, expected REN=0 v=1 wdat=deadbeef wsel=7 rw=1 stall=0",
                     dmemREN, wb_valid, wb_wdat, wb_wsel, wb_regwr, mem_stall);
        end
    endtask

    task automatic test_back_to_back();
        clear_ex();
        ex_valid = 1'b1; ex_dmemWEN = 1'b1; ex_dmemREN = 1'b1; ex_porto = 32'h40;
        ex_portb = 32'h0000_CAFE; ex_wsel = 5'd3; ex_regwr = 1'b1;
        tick();
        ex_dmemWEN = 1'b0; ex_porto = 32'h44; ex_wsel = 5'd4; ex_regsrc = 2'd1;
        dhit = 1'b1;
        #1;
        n_checks++;
        if ({dmemWEN, dmemREN, dmemaddr, dmemstore, mem_stall} !== {1'b1, 1'b0, 32'h40, 32'h0000_CAFE, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_store_req: got WEN=%b REN=%b addr=%h data=%h stall=%b, expected WEN=1 REN=0 addr=40 data=cafe stall=0",
                     dmemWEN, dmemREN, dmemaddr, dmemstore, mem_stall);
        end
        tick();
        dhit = 1'b0;
        n_checks++;
        if ({dmemWEN, dmemREN, wb_valid, wb_regwr, wb_wsel} !== {1'b0, 1'b0, 1'b1, 1'b0, 5'd3}) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: got WEN=%b REN=%b v=%b rw=%b wsel=%0d, expected WEN=0 REN=0 v=1 rw=0 wsel=3",
                     dmemWEN, dmemREN, wb_valid, wb_regwr, wb_wsel);
        end
        tick();
        clear_ex();
        dhit = 1'b1; dmemload = 32'h0000_0055;
        #1;
        n_checks++;
        if ({dmemREN, dmemWEN, dmemaddr, wb_valid} !== {1'b1, 1'b0, 32'h44, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_load_req: got REN=%b WEN=%b addr=%h v=%b, expected REN=1 WEN=0 addr=44 v=0",
                     dmemREN, dmemWEN, dmemaddr, wb_valid);
        end
        tick();
        dhit = 1'b0;
        n_checks++;
        if ({dmemREN, wb_valid, wb_wdat, wb_wsel, wb_regwr} !== {1'b0, 1'b1, 32'h55, 5'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_load_retire: got REN=%b v=%b wdat=%h wsel=%0d rw=%b, expected REN=0 v=1 wdat=55 wsel=4 rw=1",
                     dmemREN, wb_valid, wb_wdat, wb_wsel, wb_regwr);
        end
    endtask

    task automatic test_halt();
        clear_ex();
        ex_valid = 1'b1; ex_dmemREN = 1'b1; ex_porto = 32'h80; ex_wsel = 5'd2; ex_regwr = 1'b1; ex_regsrc = 2'd1;
        tick();
        clear_ex();
        ex_valid = 1'b1; ex_halt = 1'b1; ex_dmemREN = 1'b1; dmemload = 32'h1111_2222;
        #1;
        n_checks++;
        if ({mem_stall, wb_halt, dmemREN} !== 3'b101) begin
            n_fail++;
            $display("FAIL halt_behind_load: got stall=%b halt=%b REN=%b, expected 1 0 1", mem_stall, wb_halt, dmemREN);
        end
        tick();
        dhit = 1'b1;
        tick();
        dhit = 1'b0;
        n_checks++;
        if ({wb_valid, wb_wdat, wb_halt} !== {1'b1, 32'h1111_2222, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_load_first: got v=%b wdat=%h halt=%b, expected v=1 wdat=11112222 halt=0", wb_valid, wb_wdat, wb_halt);
        end
        tick();
        n_checks++;
        if ({wb_halt, wb_valid, wb_regwr, mem_stall, dmemREN} !== 5'b11010) begin
            n_fail++;
            $display("FAIL halt_retire: got halt=%b v=%b rw=%b stall=%b REN=%b, expected 1 1 0 1 0",
                     wb_halt, wb_valid, wb_regwr, mem_stall, dmemREN);
        end
        clear_ex();
        ex_valid = 1'b1; ex_dmemWEN = 1'b1; ex_porto = 32'h90; dhit = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({wb_halt, wb_valid, mem_stall, dmemREN, dmemWEN} !== 5'b10100) begin
            n_fail++;
            $display("FAIL halt_sticky: got halt=%b v=%b stall=%b REN=%b WEN=%b, expected 1 0 1 0 0",
                     wb_halt, wb_valid, mem_stall, dmemREN, dmemWEN);
        end
        clear_ex();
        RST = 1'b1;
        #2;
        RST = 1'b0;
        tick();
    endtask

    task automatic test_reset_wait();
        clear_ex();
        ex_valid = 1'b1; ex_dmemWEN = 1'b1; ex_porto = 32'hA0; ex_portb = 32'h77; ex_wsel = 5'd6;
        tick();
        clear_ex();
        n_checks++;
        if ({dmemWEN, mem_stall} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstwait_pre: got WEN=%b stall=%b, expected 1 1", dmemWEN, mem_stall);
        end
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wb_valid, wb_wdat, wb_wsel, wb_regwr, wb_halt} !== 107'd0) begin
            n_fail++;
            $display("FAIL rstwait_async: got WEN=%b addr=%h stall=%b halt=%b, expected all zero", dmemWEN, dmemaddr, mem_stall, wb_halt);
        end
        #2;
        RST = 1'b0;
        tick();
        n_checks++;
        if ({dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wb_valid, wb_wdat, wb_wsel, wb_regwr, wb_halt} !== 107'd0) begin
            n_fail++;
            $display("FAIL rstwait_release: got WEN=%b addr=%h stall=%b v=%b, expected all zero", dmemWEN, dmemaddr, mem_stall, wb_valid);
        end
        ex_valid = 1'b1; ex_porto = 32'h0000_00BB; ex_wsel = 5'd9; ex_regwr = 1'b1;
        tick();
        clear_ex();
        n_checks++;
        if ({wb_valid, wb_wdat, wb_wsel} !== {1'b1, 32'hBB, 5'd9}) begin
            n_fail++;
            $display("FAIL rstwait_idle: got v=%b wdat=%h wsel=%0d, expected v=1 wdat=bb wsel=9", wb_valid, wb_wdat, wb_wsel);
        end
    endtask

`ifdef PIPELINE_MEM_LLSC_EN
    task automatic test_llsc();
        for (int pass = 0; pass < 2; pass++) begin
            clear_ex();
            ex_valid = 1'b1; ex_ll = 1'b1; ex_dmemREN = 1'b1; ex_porto = 32'h200; ex_wsel = 5'd8; ex_regwr = 1'b1; ex_regsrc = 2'd1;
            tick();
            clear_ex();
            dhit = 1'b1; dmemload = 32'h5;
            tick();
            clear_ex();
            if (pass == 1) begin
                ccinv = 1'b1; ccsnoopaddr = 32'h200;
                tick();
                clear_ex();
            end
            ex_valid = 1'b1; ex_sc = 1'b1; ex_dmemWEN = 1'b1; ex_porto = 32'h200; ex_portb = 32'h99; ex_wsel = 5'd10; ex_regwr = 1'b1;
            tick();
            clear_ex();
            n_checks++;
            if ({dmemWEN, wb_valid} !== ((pass == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL llsc_issue[%0d]: got WEN=%b v=%b", pass, dmemWEN, wb_valid);
            end
            if (pass == 0) begin
                dhit = 1'b1;
                tick();
                dhit = 1'b0;
            end
            n_checks++;
            if ({wb_valid, wb_wdat, wb_regwr, wb_wsel, dmemWEN} !== {1'b1, ((pass == 0) ? 32'h1 : 32'h0), 1'b1, 5'd10, 1'b0}) begin
                n_fail++;
                $display("FAIL llsc_result[%0d]: got v=%b wdat=%h rw=%b wsel=%0d WEN=%b", pass, wb_valid, wb_wdat, wb_regwr, wb_wsel, dmemWEN);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_halt();
        test_reset_wait();
`ifdef PIPELINE_MEM_LLSC_EN
        test_llsc();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
